uart_rx_cfg: RTL

//  Configurable oversampling UART receiver. Runtime data length (5..DBITS), parity and 1/2 stop bits.
//  3-sample majority vote, false-start rejection, framing/parity error and break detection.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_sync.sv | 17 +
 rtl/uart_rx_cfg.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity encodings, receiver states and data-length clamp
package uart_pkg;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {LINE_WAIT, IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic int clamp_dbits(input int d, input int max_bits);
        return d < 5 ? 5 : (d > max_bits ? max_bits : d);
    endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchroniser for the idle-high serial line
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) ff <= '1;
        else ff <= {ff[STAGES-2:0], d};

    assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with runtime length/parity/stop config
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBITS       = 8,
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       rx,
    input  logic                       s_tick,
    input  logic [$clog2(DBITS+1)-1:0] cfg_dbits,
    input  logic [1:0]                 cfg_parity,
    input  logic                       cfg_stop2,
    output logic                       rx_valid,
    output logic [DBITS-1:0]           rx_dout,
    output logic                       parity_err,
    output logic                       frame_err,
    output logic                       break_det
);
    localparam int NW = $clog2(DBITS + 1);
    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] S_LO  = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] S_MID = CW'(OVS / 2);
    localparam logic [CW-1:0] S_EV  = CW'(OVS / 2 + 1);
    localparam logic [CW-1:0] S_END = CW'(OVS - 1);

    state_t state, state_nxt;
    logic rxs, maj, tick_eval, tick_end, par_en, last_data, done, start;
    logic stop2_q, par_acc, ferr_acc, zero_acc;
    logic [CW-1:0] s_cnt;
    logic [NW-1:0] n, dbits_q;
    logic [1:0] par_q, samp;
    logic [DBITS-1:0] shreg;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .reset_n(reset_n), .d(rx), .q(rxs));

    // the third sample is the live rxs on the evaluation tick
    assign maj       = (samp[1] & samp[0]) | (samp[1] & rxs) | (samp[0] & rxs);
    assign tick_eval = s_tick && s_cnt == S_EV;
    assign tick_end  = s_tick && s_cnt == S_END;
    assign par_en    = par_q == PAR_EVEN || par_q == PAR_ODD;
    assign last_data = n == dbits_q - NW'(1);
    assign done      = state == STOP && tick_eval && (!stop2_q || n != '0);
    assign start     = state == IDLE && !rxs;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= LINE_WAIT;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            LINE_WAIT: state_nxt = rxs ? IDLE : LINE_WAIT;
            IDLE:      state_nxt = rxs ? IDLE : START;
            START:     state_nxt = tick_eval && maj ? IDLE : (tick_end ? DATA : START);
            DATA:      state_nxt = tick_end && last_data ? (par_en ? PARITY : STOP) : DATA;
            PARITY:    state_nxt = tick_end ? STOP : PARITY;
            STOP:      state_nxt = !done ? STOP : (zero_acc && !maj ? LINE_WAIT : IDLE);
            default:   state_nxt = LINE_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_cnt      <= '0;
            n          <= '0;
            samp       <= '0;
            shreg      <= '0;
            dbits_q    <= '0;
            par_q      <= '0;
            stop2_q    <= 1'b0;
            par_acc    <= 1'b0;
            ferr_acc   <= 1'b0;
            zero_acc   <= 1'b0;
            rx_valid   <= 1'b0;
            rx_dout    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            rx_valid <= done;
            if (start) begin
                s_cnt    <= '0;
                n        <= '0;
                samp     <= '0;
                shreg    <= '0;
                par_acc  <= 1'b0;
                ferr_acc <= 1'b0;
                zero_acc <= 1'b1;
                dbits_q  <= NW'(clamp_dbits(32'(cfg_dbits), DBITS));
                par_q    <= cfg_parity;
                stop2_q  <= cfg_stop2;
            end else if (s_tick && state inside {START, DATA, PARITY, STOP}) begin
                s_cnt <= tick_end ? '0 : s_cnt + 1'b1;
                if (s_cnt == S_LO || s_cnt == S_MID) samp <= {samp[0], rxs};
                if (tick_end) n <= (state == DATA && !last_data) || state == STOP ? n + 1'b1 : '0;
                if (tick_eval) begin
                    zero_acc <= zero_acc & ~maj;
                    if (state == DATA) shreg <= {maj, shreg[DBITS-1:1]};
                    if (state == DATA || state == PARITY) par_acc <= par_acc ^ maj;
                    if (state == STOP) ferr_acc <= ferr_acc | ~maj;
                end
            end
            // bits enter at the MSB, so shift the frame down to right-align it
            if (done) begin
                rx_dout    <= shreg >> (DBITS - int'(dbits_q));
                parity_err <= par_en && (par_acc != (par_q == PAR_ODD));
                frame_err  <= ferr_acc | ~maj;
                break_det  <= zero_acc & ~maj;
            end
        end
    end
endmodule
